// File: rtl/transpose_skew_feeder_if.sv
// Row stream into the skew feeder and the skewed row stream out to the rotator.
// Handshake: a beat transfers on a rising edge where valid && ready; valid never waits on ready.
interface transpose_skew_feeder_if #(
  parameter int DATA_WIDTH = 3,
  parameter int NUM_PE     = 8
);
  localparam int TOTAL_WIDTH    = DATA_WIDTH * NUM_PE;
  localparam int SHIFT_AMT_BITS = $clog2(TOTAL_WIDTH);
  localparam int ROW_BITS       = $clog2(NUM_PE);

  logic                      skew_mode;
  logic [TOTAL_WIDTH-1:0]    in_bits;
  logic                      in_valid;
  logic                      in_ready;
  logic [TOTAL_WIDTH-1:0]    out_bits;
  logic [SHIFT_AMT_BITS-1:0] out_shift_amt;
  logic [ROW_BITS-1:0]       out_row_idx;
  logic                      out_last;
  logic                      out_valid;
  logic                      out_ready;
  logic                      matrix_done;

  modport master (
    output skew_mode, in_bits, in_valid, out_ready,
    input  in_ready, out_bits, out_shift_amt, out_row_idx, out_last, out_valid, matrix_done
  );

  modport slave (
    input  skew_mode, in_bits, in_valid, out_ready,
    output in_ready, out_bits, out_shift_amt, out_row_idx, out_last, out_valid, matrix_done
  );
endinterface

// File: rtl/transpose_skew_feeder.sv
// Tags matrix rows with index and skew rotation amount, buffering them in a
// 2-entry FIFO ahead of the combinational circular_shift rotator.
module transpose_skew_feeder #(
  parameter int DATA_WIDTH     = 3,
  parameter int NUM_PE         = 8,
  parameter int TOTAL_WIDTH    = DATA_WIDTH * NUM_PE,
  parameter int SHIFT_AMT_BITS = $clog2(TOTAL_WIDTH)
) (
  input logic                    clk,
  input logic                    rst,
  transpose_skew_feeder_if.slave bus
);
  localparam int ROW_BITS = $clog2(NUM_PE);

  logic [1:0]                r_count;
  logic                      r_wr_ptr;
  logic                      r_rd_ptr;
  logic [ROW_BITS-1:0]       r_row_cnt;
  logic                      r_mode_q;
  logic                      r_done;
  logic [TOTAL_WIDTH-1:0]    r_bits [2];
  logic [SHIFT_AMT_BITS-1:0] r_amt  [2];
  logic [ROW_BITS-1:0]       r_idx  [2];
  logic                      r_last [2];

  logic                      w_in_ready;
  logic                      w_out_valid;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_first_row;
  logic                      w_mode;
  logic                      w_row_last;
  logic [ROW_BITS-1:0]       w_inv_row;
  logic [SHIFT_AMT_BITS-1:0] w_fwd_amt;
  logic [SHIFT_AMT_BITS-1:0] w_inv_amt;
  logic [SHIFT_AMT_BITS-1:0] w_shift_amt;

  // Ready comes from the registered count only, so out_ready never reaches in_ready.
  assign w_in_ready  = (r_count != 2'd2);
  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  // Row 0 takes the live skew_mode; later rows reuse the mode latched on row 0.
  assign w_first_row = (r_row_cnt == '0);
  assign w_mode      = w_first_row ? bus.skew_mode : r_mode_q;
  assign w_row_last  = (r_row_cnt == ROW_BITS'(NUM_PE - 1));

  assign w_inv_row   = w_first_row ? '0 : ROW_BITS'(NUM_PE) - r_row_cnt;
  assign w_fwd_amt   = SHIFT_AMT_BITS'(r_row_cnt) * SHIFT_AMT_BITS'(DATA_WIDTH);
  assign w_inv_amt   = SHIFT_AMT_BITS'(w_inv_row) * SHIFT_AMT_BITS'(DATA_WIDTH);
  assign w_shift_amt = w_mode ? w_inv_amt : w_fwd_amt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= 2'd0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_row_cnt <= '0;
      r_mode_q  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_push) begin
        r_bits[r_wr_ptr] <= bus.in_bits;
        r_amt[r_wr_ptr]  <= w_shift_amt;
        r_idx[r_wr_ptr]  <= r_row_cnt;
        r_last[r_wr_ptr] <= w_row_last;
        r_wr_ptr         <= ~r_wr_ptr;
        r_row_cnt        <= w_row_last ? '0 : r_row_cnt + ROW_BITS'(1);
        if (w_first_row) r_mode_q <= bus.skew_mode;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      r_done <= w_pop && r_last[r_rd_ptr];
    end
  end

  // Head fields are masked to zero while the FIFO is empty.
  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_bits      = w_out_valid ? r_bits[r_rd_ptr] : '0;
  assign bus.out_shift_amt = w_out_valid ? r_amt[r_rd_ptr]  : '0;
  assign bus.out_row_idx   = w_out_valid ? r_idx[r_rd_ptr]  : '0;
  assign bus.out_last      = w_out_valid ? r_last[r_rd_ptr] : 1'b0;
  assign bus.matrix_done   = r_done;
endmodule

// File: tb/tb_transpose_skew_feeder.sv
// Bench for transpose_skew_feeder: directed scenarios plus a randomized run,
// all cross-checked per cycle against a queue-based reference model.
module tb_transpose_skew_feeder;
  localparam int DW  = 3;
  localparam int NPE = 8;
  localparam int TW  = DW * NPE;
  localparam int SAB = $clog2(TW);
  localparam int RB  = $clog2(NPE);
  localparam int W   = TW + SAB + RB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  transpose_skew_feeder_if #(.DATA_WIDTH(DW), .NUM_PE(NPE)) bus ();

  transpose_skew_feeder #(.DATA_WIDTH(DW), .NUM_PE(NPE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int pop_cnt = 0;

  // Reference model: rows as packed {bits, shift, row index, last}
  logic [W-1:0]     exp_q[$];
  int               m_row = 0;
  logic             m_mode = 1'b0;
  logic             exp_done = 1'b0;
  logic             stalled = 1'b0;
  logic [W-1:0]     stall_val;
  logic [W-1:0]     got;
  logic [W-1:0]     head;
  logic             m_push;
  logic             m_pop;
  int               m_amt;

  always @(negedge clk) begin
    if (bus.matrix_done === 1'b1) done_cnt++;
  end

  always @(negedge clk) begin
    m_push = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
    m_pop  = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
    got    = {bus.out_bits, bus.out_shift_amt, bus.out_row_idx, bus.out_last};
    head   = (exp_q.size() > 0) ? exp_q[0] : '0;
    checks++;
    if (bus.in_ready !== (exp_q.size() < 2)) begin
      errors++; $display("FAIL sb_in_ready got %b exp %b", bus.in_ready, exp_q.size() < 2);
    end
    checks++;
    if (bus.out_valid !== (exp_q.size() > 0)) begin
      errors++; $display("FAIL sb_out_valid got %b exp %b", bus.out_valid, exp_q.size() > 0);
    end
    checks++;
    if (got !== head) begin
      errors++; $display("FAIL sb_head got %h exp %h", got, head);
    end
    checks++;
    if (bus.matrix_done !== exp_done) begin
      errors++; $display("FAIL sb_matrix_done got %b exp %b", bus.matrix_done, exp_done);
    end
    if (stalled) begin
      checks++;
      if (got !== stall_val) begin
        errors++; $display("FAIL sb_stall_stable got %h exp %h", got, stall_val);
      end
    end
    if (rst) begin
      exp_q.delete();
      m_row = 0; m_mode = 1'b0; exp_done = 1'b0; stalled = 1'b0;
    end else begin
      exp_done  = m_pop && (exp_q.size() > 0) && head[0];
      stalled   = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      stall_val = got;
      if (m_pop && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        pop_cnt++;
      end
      if (m_push) begin
        if (m_row == 0) m_mode = bus.skew_mode;
        m_amt = m_mode ? ((NPE - m_row) % NPE) * DW : m_row * DW;
        exp_q.push_back({bus.in_bits, SAB'(m_amt), RB'(m_row), (m_row == NPE - 1)});
        m_row = (m_row + 1) % NPE;
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Holds the row until accepted; returns 1 time unit after the accepting edge.
  task automatic drive_row(input logic [TW-1:0] bits, input logic mode);
    int n = 0;
    bus.in_bits = bits; bus.skew_mode = mode; bus.in_valid = 1'b1;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 50) begin
      errors++; $display("FAIL push_timeout waited %0d cycles limit 50", n);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [TW-1:0] lane_ramp();
    logic [TW-1:0] b = '0;
    for (int j = 0; j < NPE; j++) b[j*DW +: DW] = DW'(j);
    return b;
  endfunction

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.matrix_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.matrix_done); end
    checks++;
    if ({bus.out_bits, bus.out_shift_amt, bus.out_row_idx, bus.out_last} !== '0) begin
      errors++; $display("FAIL rst_out_fields got %h exp 0", bus.out_bits);
    end
  endtask

  task automatic test_skew(input logic inverse);
    int inv_tab [NPE] = '{0, 21, 18, 15, 12, 9, 6, 3};
    int exp_amt;
    logic [TW-1:0] b = lane_ramp();
    apply_reset();
    bus.out_ready = 1'b1;
    for (int r = 0; r < NPE; r++) begin
      drive_row(b, inverse ? ((r == 0) ? 1'b1 : (r % 2 == 0)) : 1'b0);
      exp_amt = inverse ? inv_tab[r] : r * DW;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL skew_latency row %0d valid %b exp 1", r, bus.out_valid); end
      checks++; if (bus.out_row_idx !== RB'(r)) begin errors++; $display("FAIL skew_idx got %0d exp %0d", bus.out_row_idx, r); end
      checks++; if (bus.out_shift_amt !== SAB'(exp_amt)) begin errors++; $display("FAIL skew_amt row %0d got %0d exp %0d", r, bus.out_shift_amt, exp_amt); end
      checks++; if (bus.out_last !== (r == NPE - 1)) begin errors++; $display("FAIL skew_last row %0d got %b", r, bus.out_last); end
      checks++; if (bus.out_bits !== b) begin errors++; $display("FAIL skew_bits got %h exp %h", bus.out_bits, b); end
    end
    @(posedge clk); #1;
    checks++; if (bus.matrix_done !== 1'b1) begin errors++; $display("FAIL skew_done_pulse got %b exp 1", bus.matrix_done); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL skew_drained got %b exp 0", bus.out_valid); end
    @(posedge clk); #1;
    checks++; if (bus.matrix_done !== 1'b0) begin errors++; $display("FAIL skew_done_single got %b exp 0", bus.matrix_done); end
  endtask

  task automatic test_backpressure();
    logic [TW-1:0] a = 24'h123456, b = 24'hABCDEF, c = 24'h0F0F0F;
    apply_reset();
    bus.out_ready = 1'b0;
    drive_row(a, 1'b0);
    drive_row(b, 1'b0);
    bus.in_bits = c; bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", bus.in_ready); end
      checks++; if (bus.out_bits !== a) begin errors++; $display("FAIL bp_head_hold got %h exp %h", bus.out_bits, a); end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_lag got %b exp 0", bus.in_ready); end
    drive_row(c, 1'b0);
    checks++; if (bus.out_bits !== c || bus.out_row_idx !== RB'(2)) begin
      errors++; $display("FAIL bp_order got %h idx %0d exp %h idx 2", bus.out_bits, bus.out_row_idx, c);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int d0;
    int exp_amt;
    logic [TW-1:0] b;
    apply_reset();
    bus.out_ready = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 2 * NPE; i++) begin
      b = TW'($urandom);
      drive_row(b, (i >= NPE));
      exp_amt = (i < NPE) ? (i % NPE) * DW : ((NPE - (i % NPE)) % NPE) * DW;
      checks++; if (bus.out_row_idx !== RB'(i % NPE)) begin errors++; $display("FAIL b2b_idx got %0d exp %0d", bus.out_row_idx, i % NPE); end
      checks++; if (bus.out_shift_amt !== SAB'(exp_amt)) begin errors++; $display("FAIL b2b_amt row %0d got %0d exp %0d", i, bus.out_shift_amt, exp_amt); end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_row(TW'($urandom), 1'b0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    drive_row(TW'($urandom), 1'b0);
    drive_row(TW'($urandom), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    drive_row(TW'($urandom), 1'b1);
    checks++; if (bus.out_row_idx !== RB'(0) || bus.out_shift_amt !== SAB'(0)) begin
      errors++; $display("FAIL mid_rst_row0 idx %0d amt %0d exp 0 0", bus.out_row_idx, bus.out_shift_amt);
    end
    drive_row(TW'($urandom), 1'b0);
    checks++; if (bus.out_row_idx !== RB'(1) || bus.out_shift_amt !== SAB'(21)) begin
      errors++; $display("FAIL mid_rst_row1 idx %0d amt %0d exp 1 21", bus.out_row_idx, bus.out_shift_amt);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int p0;
    logic rows_done = 1'b0;
    apply_reset();
    p0 = pop_cnt;
    fork
      begin
        for (int i = 0; i < 64; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          drive_row(TW'($urandom), 1'($urandom_range(0, 1)));
        end
        rows_done = 1'b1;
      end
      begin
        while (!rows_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (pop_cnt - p0 != 64) begin errors++; $display("FAIL rand_pop_count got %0d exp 64", pop_cnt - p0); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rand_drained got %b exp 0", bus.out_valid); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_bits = '0; bus.skew_mode = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_skew(1'b0);
    test_skew(1'b1);
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
